// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: operand-source handshake and job control bundle for systolic_ctrl
interface systolic_ctrl_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int KW = 8
);
  logic           start;
  logic [KW-1:0]  k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           busy;
  logic           done;
  modport slave  (input start, k_len, in_valid, in_a, in_b, output in_ready, busy, done);
  modport master (output start, k_len, in_valid, in_a, in_b, input in_ready, busy, done);
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears an NxN output-stationary MAC array, feeds K skewed operand beats, pulses done
module systolic_ctrl #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int KW = 8
) (
  input  logic           clk,
  input  logic           nrst,
  systolic_ctrl_if.slave src,
  output logic [N*W-1:0] x_edge,
  output logic [N*W-1:0] y_edge,
  output logic           arr_clr_n
);
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;
  localparam int CW = $clog2(2*N-1);
  localparam logic [CW-1:0] DRN = CW'(2*N-2);
  state_t        state;
  logic [KW-1:0] k_rem;
  logic [CW-1:0] cnt;
  logic          done_r;
  logic          beat;
  assign src.in_ready = state == FEED;
  assign src.busy     = state != IDLE;
  assign src.done     = done_r;
  assign beat         = src.in_valid && state == FEED;
  // job sequencing: one clear cycle, K accepted beats, then 2N-2 drain cycles until the last PE settles
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state     <= IDLE;
      k_rem     <= '0;
      cnt       <= '0;
      done_r    <= 1'b0;
      arr_clr_n <= 1'b1;
    end else begin
      done_r    <= 1'b0;
      arr_clr_n <= 1'b1;
      case (state)
        IDLE:
          if (src.start) begin
            k_rem     <= src.k_len;
            arr_clr_n <= 1'b0;
            state     <= CLEAR;
          end
        CLEAR: begin
          state <= k_rem != '0 ? FEED : DRAIN;
          cnt   <= DRN;
        end
        FEED:
          if (src.in_valid) begin
            k_rem <= k_rem - 1'b1;
            if (k_rem == KW'(1)) begin
              state <= DRAIN;
              cnt   <= DRN;
            end
          end
        DRAIN:
          if (cnt == '0) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end else
            cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [W-1:0] xs [0:i];
    logic [W-1:0] ys [0:i];
    // row/column i is delayed i cycles plus an output register; idle cycles push zeros so stalls add nothing
    always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
        for (int k = 0; k <= i; k++) begin
          xs[k] <= '0;
          ys[k] <= '0;
        end
      end else begin
        xs[0] <= beat ? src.in_a[i*W +: W] : '0;
        ys[0] <= beat ? src.in_b[i*W +: W] : '0;
        for (int k = 1; k <= i; k++) begin
          xs[k] <= xs[k-1];
          ys[k] <= ys[k-1];
        end
      end
    assign x_edge[i*W +: W] = xs[i];
    assign y_edge[i*W +: W] = ys[i];
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized scoreboard bench for systolic_ctrl driving a behavioural PE array
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KW = 8;
  typedef struct {int s; int el; int d;} job_t;

  logic           clk  = 1'b0;
  logic           nrst = 1'b1;
  logic [N*W-1:0] x_edge, y_edge;
  logic           arr_clr_n;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;

  job_t           jobs [$];
  int             exp_res [$];
  logic [N*W-1:0] exp_x [int];
  logic [N*W-1:0] exp_y [int];
  logic [N*W-1:0] ja [64];
  logic [N*W-1:0] jb [64];
  int             gaps [64];

  int                   acc [N][N];
  logic signed [W-1:0]  xr [N][N];
  logic signed [W-1:0]  yr [N][N];
  logic signed [W-1:0]  xi, yi;

  systolic_ctrl_if #(.N(N), .W(W), .KW(KW)) bus ();
  systolic_ctrl #(.N(N), .W(W), .KW(KW)) dut (
    .clk(clk), .nrst(nrst), .src(bus.slave),
    .x_edge(x_edge), .y_edge(y_edge), .arr_clr_n(arr_clr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output-stationary array: x moves right, y moves down, each PE accumulates x*y
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= 0;
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          xi = (j == 0) ? $signed(x_edge[i*W +: W]) : xr[i][(j == 0) ? 0 : j-1];
          yi = (i == 0) ? $signed(y_edge[j*W +: W]) : yr[(i == 0) ? 0 : i-1][j];
          xr[i][j]  <= xi;
          yr[i][j]  <= yi;
          acc[i][j] <= !arr_clr_n ? 0 : acc[i][j] + int'(xi) * int'(yi);
        end
    end
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [N*W-1:0] rnd_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // monitor: compares every cycle against the job timeline; checks array results on the done cycle
  logic er, eb, ec, ed;
  int   c;
  always @(negedge clk) if (nrst) begin
    c  = cyc;
    er = 1'b0; eb = 1'b0; ec = 1'b0; ed = 1'b0;
    if (jobs.size() > 0 && c >= jobs[0].s) begin
      er = c >= jobs[0].s + 1 && c <= jobs[0].el - 1;
      eb = c < jobs[0].d;
      ec = c == jobs[0].s;
      ed = c == jobs[0].d;
    end
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("busy", 64'(bus.busy), 64'(eb));
    chk("arr_clr_n", 64'(arr_clr_n), 64'(!ec));
    chk("done", 64'(bus.done), 64'(ed));
    chk("x_edge", 64'(x_edge), 64'(exp_x.exists(c) ? exp_x[c] : '0));
    chk("y_edge", 64'(y_edge), 64'(exp_y.exists(c) ? exp_y[c] : '0));
    if (jobs.size() > 0 && c == jobs[0].d) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          chk($sformatf("result[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(exp_res.pop_front()));
      void'(jobs.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_arr_clr_n", 64'(arr_clr_n), 64'(1));
    chk("rst_x_edge", 64'(x_edge), 64'(0));
    chk("rst_y_edge", 64'(y_edge), 64'(0));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check_rst();
    jobs.delete();
    exp_res.delete();
    exp_x.delete();
    exp_y.delete();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    tick();
  endtask

  // stimulus: plans beat edges from the stall pattern, records expectations, then drives the job
  task automatic run_job(input int k, input bit b2b, input int abort, input bit poke);
    job_t j;
    int e;
    logic [N*W-1:0] t;
    j.s = cyc + 1;
    e = j.s + 1;
    for (int kk = 0; kk < k; kk++) e += gaps[kk] + 1;
    j.el = e;
    j.d  = e + 2*N - 1;
    for (int q = j.s; q <= j.d; q++) begin
      exp_x[q] = '0;
      exp_y[q] = '0;
    end
    e = j.s + 1;
    for (int kk = 0; kk < k; kk++) begin
      e += gaps[kk] + 1;
      for (int i = 0; i < N; i++) begin
        t = exp_x[e+i]; t[i*W +: W] = ja[kk][i*W +: W]; exp_x[e+i] = t;
        t = exp_y[e+i]; t[i*W +: W] = jb[kk][i*W +: W]; exp_y[e+i] = t;
      end
    end
    for (int i = 0; i < N; i++)
      for (int jj = 0; jj < N; jj++) begin
        int sum;
        sum = 0;
        for (int kk = 0; kk < k; kk++)
          sum += int'($signed(ja[kk][i*W +: W])) * int'($signed(jb[kk][jj*W +: W]));
        exp_res.push_back(sum);
      end
    jobs.push_back(j);
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    tick();
    bus.start = 1'b0;
    bus.k_len = KW'($urandom);
    tick();
    for (int kk = 0; kk < k; kk++) begin
      if (kk == abort) begin
        do_reset();
        return;
      end
      repeat (gaps[kk]) tick();
      bus.in_valid = 1'b1;
      bus.in_a = ja[kk];
      bus.in_b = jb[kk];
      if (poke && kk == 0) begin
        bus.start = 1'b1;
        bus.k_len = KW'($urandom_range(1, 9));
      end
      tick();
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      bus.in_a = rnd_vec();
      bus.in_b = rnd_vec();
    end
    while (cyc < j.d) tick();
    if (!b2b) tick();
  endtask

  task automatic set_ident();
    for (int kk = 0; kk < N; kk++) begin
      ja[kk] = '0;
      jb[kk] = '0;
      ja[kk][kk*W +: W] = W'(1);
      jb[kk][kk*W +: W] = W'(1);
      gaps[kk] = 0;
    end
  endtask

  task automatic fill_rand(input int k, input int pct);
    for (int kk = 0; kk < k; kk++) begin
      ja[kk] = rnd_vec();
      jb[kk] = rnd_vec();
      gaps[kk] = ($urandom_range(0, 99) < pct) ? $urandom_range(1, 3) : 0;
    end
  endtask

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    #1 nrst = 1'b0;
    #1 check_rst();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    tick();
    set_ident();
    run_job(4, 1'b0, -1, 1'b0);
    set_ident();
    gaps[2] = 3;
    run_job(4, 1'b0, -1, 1'b0);
    for (int kk = 0; kk < 4; kk++) begin
      for (int i = 0; i < N; i++) begin
        ja[kk][i*W +: W] = W'(127);
        jb[kk][i*W +: W] = W'(-128);
      end
      gaps[kk] = 0;
    end
    run_job(4, 1'b1, -1, 1'b0);
    fill_rand(5, 0);
    run_job(5, 1'b0, -1, 1'b0);
    run_job(0, 1'b0, -1, 1'b0);
    fill_rand(6, 0);
    run_job(6, 1'b0, 2, 1'b0);
    fill_rand(6, 30);
    run_job(6, 1'b0, -1, 1'b1);
    repeat (25) begin
      k = $urandom_range(0, 12);
      fill_rand(k, 25);
      run_job(k, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
    end
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
